// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch sequencer and the instruction register:
// FSM state encoding, the halt opcode and the instruction field positions.
package fetch_unit_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_LOAD  = 3'd2,
      ST_EXEC  = 3'd3,
      ST_HALT  = 3'd4
   } fetch_state_e;

   localparam logic [3:0] HALT_OPCODE = 4'hF;

   // Instruction word layout: opcode in the low nibble, immediate/register in the high nibble
   localparam int OPC_LSB = 0;
   localparam int OPC_MSB = 3;
   localparam int IMM_LSB = 4;
   localparam int IMM_MSB = 7;

   function automatic logic [3:0] get_opcode(input logic [7:0] ins);
      return ins[OPC_MSB:OPC_LSB];
   endfunction

   function automatic logic [3:0] get_imm(input logic [7:0] ins);
      return ins[IMM_MSB:IMM_LSB];
   endfunction

endpackage

// File: rtl/fetch_unit_pc_counter.sv
// Program counter register: reset value, load (redirect) or increment by one.
// Load wins over increment; the increment wraps modulo 2^ADDR_W.
module fetch_unit_pc_counter #(
   parameter int                 ADDR_W   = 8,
   parameter logic [ADDR_W-1:0]  RESET_PC = {ADDR_W{1'b0}}
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_val,
   input  logic              inc_en,
   output logic [ADDR_W-1:0] pc
);

   logic [ADDR_W-1:0] pc_d;
   logic [ADDR_W-1:0] pc_q;

   // Select the next PC value
   always_comb begin
      pc_d = pc_q;
      if (load_en) begin
         pc_d = load_val;
      end else if (inc_en) begin
         pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else begin
         pc_d = pc_q;
      end
   end

   // PC register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: fetches one word over req/ack, strobes the
// instruction register, waits for execute to finish, then advances or jumps.
// All outputs come straight from flops; next values are decoded from the
// next state so strobes line up with the state they describe.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                 ADDR_W   = 8,
   parameter int                 INS_W    = 8,
   parameter logic [ADDR_W-1:0]  RESET_PC = {ADDR_W{1'b0}},
   parameter logic [3:0]         HALT_OP  = HALT_OPCODE
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [INS_W-1:0]  mem_rdata,
   output logic [INS_W-1:0]  ins_reg,
   output logic              loadIR,
   input  logic              ins_done,
   input  logic              jump_en,
   input  logic [ADDR_W-1:0] jump_addr,
   output logic [ADDR_W-1:0] pc,
   output logic              halted
);

   fetch_state_e      state_d, state_q;
   logic [INS_W-1:0]  ins_d, ins_q;
   logic              mem_req_d, mem_req_q;
   logic              load_ir_d, load_ir_q;
   logic              halted_d, halted_q;
   logic              pc_load_s;
   logic              pc_inc_s;
   logic [ADDR_W-1:0] pc_s;

   // Next-state, instruction capture and PC control decode
   always_comb begin
      state_d   = state_q;
      ins_d     = ins_q;
      pc_load_s = 1'b0;
      pc_inc_s  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (run) begin
               state_d = ST_FETCH;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FETCH: begin
            // run is not looked at here: an outstanding request always completes
            if (mem_ack) begin
               ins_d    = mem_rdata;
               pc_inc_s = 1'b1;
               state_d  = ST_LOAD;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_LOAD: begin
            if (get_opcode(ins_q) == HALT_OP) begin
               state_d = ST_HALT;
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (ins_done) begin
               pc_load_s = jump_en;
               if (run) begin
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      mem_req_d = (state_d == ST_FETCH);
      load_ir_d = (state_d == ST_LOAD);
      halted_d  = (state_d == ST_HALT);
   end

   // FSM state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         ins_q     <= {INS_W{1'b0}};
         mem_req_q <= 1'b0;
         load_ir_q <= 1'b0;
         halted_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         ins_q     <= ins_d;
         mem_req_q <= mem_req_d;
         load_ir_q <= load_ir_d;
         halted_q  <= halted_d;
      end
   end

   fetch_unit_pc_counter #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_en  (pc_load_s),
      .load_val (jump_addr),
      .inc_en   (pc_inc_s),
      .pc       (pc_s)
   );

   assign mem_req  = mem_req_q;
   assign mem_addr = pc_s;
   assign ins_reg  = ins_q;
   assign loadIR   = load_ir_q;
   assign pc       = pc_s;
   assign halted   = halted_q;

endmodule
